alu_dispatch_controller: RTL and testbench

ALU_DISPATCH_CONTROLLER -- requirements
Module: alu_dispatch_controller

---
 rtl/alu_dispatch_controller_if.sv | 46 ++++
 rtl/alu_dispatch_controller.sv | 187 ++++++++++++++++++
 tb/tb_alu_dispatch_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_dispatch_controller_if.sv
// Signal bundle between the ALU dispatch controller, its four ALU units and the register file.
// The slave modport is the controller's side. The master modport is the surrounding pipeline.
interface alu_dispatch_controller_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd_index;

  logic        lui_enable;
  logic        auipc_enable;
  logic        op_imm_enable;
  logic        op_enable;

  logic [31:0] lui_rd_value;
  logic [31:0] auipc_rd_value;
  logic [31:0] op_imm_rd_value;
  logic [31:0] op_rd_value;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd_index;
  logic [31:0] wb_rd_value;

  logic        illegal_opcode;
  logic        stall_flag;

  modport slave (
    input  issue_valid, opcode, rd_index,
    input  lui_rd_value, auipc_rd_value, op_imm_rd_value, op_rd_value,
    input  wb_ready,
    output issue_ready,
    output lui_enable, auipc_enable, op_imm_enable, op_enable,
    output wb_valid, wb_rd_index, wb_rd_value,
    output illegal_opcode, stall_flag
  );

  modport master (
    output issue_valid, opcode, rd_index,
    output lui_rd_value, auipc_rd_value, op_imm_rd_value, op_rd_value,
    output wb_ready,
    input  issue_ready,
    input  lui_enable, auipc_enable, op_imm_enable, op_enable,
    input  wb_valid, wb_rd_index, wb_rd_value,
    input  illegal_opcode, stall_flag
  );
endinterface

// File: rtl/alu_dispatch_controller.sv
// Single-issue dispatcher that steps one instruction through the lui, auipc, op_imm or op unit.
// It then hands the unit's result to the register file through a valid/ready writeback.
module alu_dispatch_controller #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic                        clock,
  input  logic                        reset_n,
  alu_dispatch_controller_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXECUTE   = 2'd1,
    CAPTURE   = 2'd2,
    WRITEBACK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    UNIT_LUI    = 2'd0,
    UNIT_AUIPC  = 2'd1,
    UNIT_OP_IMM = 2'd2,
    UNIT_OP     = 2'd3
  } unit_e;

  localparam logic [7:0] STALL_LIMIT_C = 8'(STALL_LIMIT);

  // Returns {legal, unit}. An unsupported opcode yields legal = 0.
  function automatic logic [2:0] decode_opcode(input logic [6:0] op);
    logic [2:0] res;
    case (op)
      7'b0110111: res = {1'b1, UNIT_LUI};
      7'b0010111: res = {1'b1, UNIT_AUIPC};
      7'b0010011: res = {1'b1, UNIT_OP_IMM};
      7'b0110011: res = {1'b1, UNIT_OP};
      default:    res = 3'b000;
    endcase
    return res;
  endfunction

  state_e      state_q;
  unit_e       unit_q;
  logic [4:0]  rd_q;
  logic        issue_ready_q;
  logic        illegal_q;
  logic        lui_en_q;
  logic        auipc_en_q;
  logic        op_imm_en_q;
  logic        op_en_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_index_q;
  logic [31:0] wb_rd_value_q;
  logic [7:0]  stall_cnt_q;
  logic        stall_flag_q;

  logic [2:0]  dec_s;
  logic        accept_s;
  logic [3:0]  en_oh_d;
  logic [31:0] sel_value_d;
  logic [7:0]  stall_cnt_d;

  assign dec_s    = decode_opcode(bus.opcode);
  assign accept_s = bus.issue_valid & issue_ready_q;

  // Select the one-hot enable pattern {lui, auipc, op_imm, op} for the incoming opcode.
  always_comb begin
    en_oh_d = 4'b0000;
    if (dec_s[2]) begin
      case (unit_e'(dec_s[1:0]))
        UNIT_LUI:    en_oh_d = 4'b1000;
        UNIT_AUIPC:  en_oh_d = 4'b0100;
        UNIT_OP_IMM: en_oh_d = 4'b0010;
        UNIT_OP:     en_oh_d = 4'b0001;
        default:     en_oh_d = 4'b0000;
      endcase
    end else begin
      en_oh_d = 4'b0000;
    end
  end

  // Pick the result bus of the unit that was enabled in the previous cycle.
  always_comb begin
    sel_value_d = 32'h0000_0000;
    case (unit_q)
      UNIT_LUI:    sel_value_d = bus.lui_rd_value;
      UNIT_AUIPC:  sel_value_d = bus.auipc_rd_value;
      UNIT_OP_IMM: sel_value_d = bus.op_imm_rd_value;
      UNIT_OP:     sel_value_d = bus.op_rd_value;
      default:     sel_value_d = 32'h0000_0000;
    endcase
  end

  // Saturating increment of the writeback stall counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_q == 8'hFF) begin
      stall_cnt_d = stall_cnt_q;
    end else begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  // Dispatch FSM. All outputs are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      unit_q        <= UNIT_LUI;
      rd_q          <= 5'd0;
      issue_ready_q <= 1'b0;
      illegal_q     <= 1'b0;
      lui_en_q      <= 1'b0;
      auipc_en_q    <= 1'b0;
      op_imm_en_q   <= 1'b0;
      op_en_q       <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_rd_index_q <= 5'd0;
      wb_rd_value_q <= 32'h0000_0000;
      stall_cnt_q   <= 8'd0;
      stall_flag_q  <= 1'b0;
    end else begin
      illegal_q   <= 1'b0;
      lui_en_q    <= 1'b0;
      auipc_en_q  <= 1'b0;
      op_imm_en_q <= 1'b0;
      op_en_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s && dec_s[2]) begin
            state_q       <= EXECUTE;
            unit_q        <= unit_e'(dec_s[1:0]);
            rd_q          <= bus.rd_index;
            issue_ready_q <= 1'b0;
            {lui_en_q, auipc_en_q, op_imm_en_q, op_en_q} <= en_oh_d;
          end else begin
            // Illegal opcodes are consumed in place and the controller stays ready.
            illegal_q     <= accept_s;
            issue_ready_q <= 1'b1;
          end
        end
        EXECUTE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          wb_rd_value_q <= sel_value_d;
          wb_rd_index_q <= rd_q;
          if (rd_q == 5'd0) begin
            state_q       <= IDLE;
            issue_ready_q <= 1'b1;
          end else begin
            state_q    <= WRITEBACK;
            wb_valid_q <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (bus.wb_ready) begin
            state_q       <= IDLE;
            wb_valid_q    <= 1'b0;
            issue_ready_q <= 1'b1;
            stall_cnt_q   <= 8'd0;
            stall_flag_q  <= 1'b0;
          end else begin
            stall_cnt_q  <= stall_cnt_d;
            stall_flag_q <= (stall_cnt_d >= STALL_LIMIT_C);
          end
        end
        default: begin
          state_q       <= IDLE;
          wb_valid_q    <= 1'b0;
          issue_ready_q <= 1'b1;
          stall_cnt_q   <= 8'd0;
          stall_flag_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue_ready    = issue_ready_q;
  assign bus.illegal_opcode = illegal_q;
  assign bus.lui_enable     = lui_en_q;
  assign bus.auipc_enable   = auipc_en_q;
  assign bus.op_imm_enable  = op_imm_en_q;
  assign bus.op_enable      = op_en_q;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_rd_index    = wb_rd_index_q;
  assign bus.wb_rd_value    = wb_rd_value_q;
  assign bus.stall_flag     = stall_flag_q;

endmodule

// File: tb/tb_alu_dispatch_controller.sv
// Directed bench for alu_dispatch_controller. It uses hand-computed expectations and samples on the falling edge.
module tb_alu_dispatch_controller;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [31:0] V_LUI     = 32'h1234_5000;
  localparam logic [31:0] V_AUIPC   = 32'hA000_0004;
  localparam logic [31:0] V_IMM     = 32'h0000_002A;
  localparam logic [31:0] V_OP      = 32'hDEAD_BEEF;

  logic clock;
  logic reset_n;
  int   n_vec;
  int   n_err;

  alu_dispatch_controller_if bus_if ();

  alu_dispatch_controller #(.STALL_LIMIT(15)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] en_vec();
    return {bus_if.lui_enable, bus_if.auipc_enable, bus_if.op_imm_enable, bus_if.op_enable};
  endfunction

  // Issues one instruction from IDLE with wb_ready=1 and checks every cycle of its latency.
  task automatic run_issue(input string tag, input logic [6:0] op, input logic [4:0] rd,
                           input logic [3:0] exp_en, input logic [31:0] exp_val);
    chk({tag, "_ready0"}, bus_if.issue_ready, 32'd1);
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = op;
    bus_if.rd_index    = rd;
    @(negedge clock);
    bus_if.issue_valid = 1'b0;
    chk({tag, "_en_n1"}, en_vec(), {28'd0, exp_en});
    chk({tag, "_ready_n1"}, bus_if.issue_ready, 32'd0);
    chk({tag, "_wbv_n1"}, bus_if.wb_valid, 32'd0);
    @(negedge clock);
    chk({tag, "_en_n2"}, en_vec(), 32'd0);
    chk({tag, "_wbv_n2"}, bus_if.wb_valid, 32'd0);
    @(negedge clock);
    if (rd != 5'd0) begin
      chk({tag, "_wbv_n3"}, bus_if.wb_valid, 32'd1);
      chk({tag, "_wbidx_n3"}, bus_if.wb_rd_index, {27'd0, rd});
      chk({tag, "_wbval_n3"}, bus_if.wb_rd_value, exp_val);
      @(negedge clock);
      chk({tag, "_wbv_n4"}, bus_if.wb_valid, 32'd0);
      chk({tag, "_ready_n4"}, bus_if.issue_ready, 32'd1);
    end else begin
      chk({tag, "_wbv_n3"}, bus_if.wb_valid, 32'd0);
      chk({tag, "_ready_n3"}, bus_if.issue_ready, 32'd1);
    end
  endtask

  initial begin
    logic [6:0]  b2b_op  [4];
    logic [4:0]  b2b_rd  [4];
    logic [31:0] b2b_val [4];
    int          acc_cnt;
    int          wb_cnt;
    int          last_acc;
    int          cur;
    logic        pending;

    n_vec = 0;
    n_err = 0;
    reset_n                 = 1'b0;
    bus_if.issue_valid      = 1'b0;
    bus_if.opcode           = 7'd0;
    bus_if.rd_index         = 5'd0;
    bus_if.wb_ready         = 1'b0;
    bus_if.lui_rd_value     = V_LUI;
    bus_if.auipc_rd_value   = V_AUIPC;
    bus_if.op_imm_rd_value  = V_IMM;
    bus_if.op_rd_value      = V_OP;

    repeat (3) @(negedge clock);
    chk("rst_ready", bus_if.issue_ready, 32'd0);
    chk("rst_en", en_vec(), 32'd0);
    chk("rst_wbv", bus_if.wb_valid, 32'd0);
    chk("rst_wbidx", bus_if.wb_rd_index, 32'd0);
    chk("rst_wbval", bus_if.wb_rd_value, 32'd0);
    chk("rst_illegal", bus_if.illegal_opcode, 32'd0);
    chk("rst_stall", bus_if.stall_flag, 32'd0);
    reset_n = 1'b1;
    chk("rel_ready_pre", bus_if.issue_ready, 32'd0);
    @(negedge clock);
    chk("rel_ready_post", bus_if.issue_ready, 32'd1);

    bus_if.wb_ready = 1'b1;
    run_issue("lui", OP_LUI, 5'd5, 4'b1000, V_LUI);
    run_issue("op_rd0", OP_OP, 5'd0, 4'b0001, V_OP);

    // Unsupported opcode is consumed without leaving IDLE.
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = OP_BRANCH;
    bus_if.rd_index    = 5'd9;
    @(negedge clock);
    bus_if.issue_valid = 1'b0;
    chk("ill_pulse", bus_if.illegal_opcode, 32'd1);
    chk("ill_en", en_vec(), 32'd0);
    chk("ill_ready", bus_if.issue_ready, 32'd1);
    @(negedge clock);
    chk("ill_clear", bus_if.illegal_opcode, 32'd0);
    chk("ill_wbv", bus_if.wb_valid, 32'd0);

    // Toggling wb_ready while idle must not disturb anything.
    bus_if.wb_ready = 1'b0;
    @(negedge clock);
    bus_if.wb_ready = 1'b1;
    @(negedge clock);
    chk("idle_wbr_wbv", bus_if.wb_valid, 32'd0);
    chk("idle_wbr_stall", bus_if.stall_flag, 32'd0);
    chk("idle_wbr_ready", bus_if.issue_ready, 32'd1);

    // auipc with a 20-cycle writeback stall.
    bus_if.wb_ready    = 1'b0;
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = OP_AUIPC;
    bus_if.rd_index    = 5'd1;
    @(negedge clock);
    bus_if.issue_valid = 1'b0;
    chk("auipc_en", en_vec(), 32'b0100);
    repeat (2) @(negedge clock);
    chk("auipc_wbv", bus_if.wb_valid, 32'd1);
    chk("auipc_stall0", bus_if.stall_flag, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      chk($sformatf("stall_flag_k%0d", k), bus_if.stall_flag, (k >= 15) ? 32'd1 : 32'd0);
      chk($sformatf("stall_wbv_k%0d", k), bus_if.wb_valid, 32'd1);
      chk($sformatf("stall_idx_k%0d", k), bus_if.wb_rd_index, 32'd1);
      chk($sformatf("stall_val_k%0d", k), bus_if.wb_rd_value, V_AUIPC);
    end
    bus_if.wb_ready = 1'b1;
    @(negedge clock);
    chk("stall_clear_flag", bus_if.stall_flag, 32'd0);
    chk("stall_clear_wbv", bus_if.wb_valid, 32'd0);
    chk("stall_clear_ready", bus_if.issue_ready, 32'd1);

    // Reset during EXECUTE of op_imm.
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = OP_IMM;
    bus_if.rd_index    = 5'd3;
    @(negedge clock);
    bus_if.issue_valid = 1'b0;
    chk("abort_en_exec", en_vec(), 32'b0010);
    reset_n = 1'b0;
    #1;
    chk("abort_en_now", en_vec(), 32'd0);
    chk("abort_ready_now", bus_if.issue_ready, 32'd0);
    repeat (2) @(negedge clock);
    chk("abort_wbv", bus_if.wb_valid, 32'd0);
    chk("abort_wbval", bus_if.wb_rd_value, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("abort_ready_rel", bus_if.issue_ready, 32'd1);
    run_issue("post_rst", OP_LUI, 5'd7, 4'b1000, V_LUI);

    // Four back-to-back instructions on a continuously asserted issue_valid.
    b2b_op[0] = OP_LUI;   b2b_rd[0] = 5'd10; b2b_val[0] = V_LUI;
    b2b_op[1] = OP_AUIPC; b2b_rd[1] = 5'd11; b2b_val[1] = V_AUIPC;
    b2b_op[2] = OP_IMM;   b2b_rd[2] = 5'd12; b2b_val[2] = V_IMM;
    b2b_op[3] = OP_OP;    b2b_rd[3] = 5'd31; b2b_val[3] = V_OP;
    acc_cnt  = 0;
    wb_cnt   = 0;
    last_acc = 0;
    cur      = 0;
    pending  = 1'b0;
    bus_if.issue_valid = 1'b1;
    bus_if.opcode      = b2b_op[0];
    bus_if.rd_index    = b2b_rd[0];
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (bus_if.wb_valid) begin
        if (wb_cnt < 4) begin
          chk($sformatf("b2b_wbidx%0d", wb_cnt), bus_if.wb_rd_index, {27'd0, b2b_rd[wb_cnt]});
          chk($sformatf("b2b_wbval%0d", wb_cnt), bus_if.wb_rd_value, b2b_val[wb_cnt]);
        end else begin
          chk("b2b_extra_wb", bus_if.wb_valid, 32'd0);
        end
        wb_cnt++;
      end
      if (bus_if.issue_valid && bus_if.issue_ready) begin
        if (acc_cnt > 0) begin
          chk($sformatf("b2b_spacing%0d", acc_cnt), cyc - last_acc, 32'd4);
        end
        last_acc = cyc;
        acc_cnt++;
        pending = 1'b1;
      end
      @(negedge clock);
      if (pending) begin
        pending = 1'b0;
        cur++;
        if (cur < 4) begin
          bus_if.opcode   = b2b_op[cur];
          bus_if.rd_index = b2b_rd[cur];
        end else begin
          bus_if.issue_valid = 1'b0;
        end
      end
    end
    chk("b2b_accepts", acc_cnt, 32'd4);
    chk("b2b_writes", wb_cnt, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
